// File: rtl/periph_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : periph_pkg                                                       |
// | Brief   : Shared state encoding and register map for the peripheral bus.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package periph_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3,
        ST_POLL  = 3'd4
    } state_e;

    // Hex digits occupy 0..10, the decimal point sits just above them.
    localparam logic [3:0] C_HEX_ADDR_FIRST = 4'h0;
    localparam logic [3:0] C_HEX_ADDR_LAST  = 4'hA;
    localparam logic [3:0] C_DOT_ADDR       = 4'hB;
    localparam logic [3:0] C_KEY_ADDR       = 4'hF;

    localparam int unsigned C_POLL_PERIOD_DEF = 25000;

    function automatic logic is_hex_addr(input logic [3:0] a);
        return a <= C_HEX_ADDR_LAST;
    endfunction

endpackage
`default_nettype wire

// File: rtl/periph_poll_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : periph_poll_timer                                                |
// | Brief   : Free-running keypad poll timer with a single pending flag.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module periph_poll_timer
    import periph_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = C_POLL_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic poll_en,
    input  logic poll_done,
    output logic poll_pending
);

    localparam int unsigned C_CNT_W = $clog2(POLL_PERIOD);

    logic [C_CNT_W-1:0] count_q, count_d;
    logic               pending_q, pending_d;
    logic               w_wrap;

    always_comb begin
        w_wrap    = poll_en && (count_q == C_CNT_W'(POLL_PERIOD - 1));
        count_d   = count_q;
        pending_d = pending_q;
        if (!poll_en) begin
            count_d   = '0;
            pending_d = 1'b0;
        end else begin
            count_d = w_wrap ? '0 : count_q + 1'b1;
            if (poll_done) pending_d = 1'b0;
            // A wrap while already pending simply re-asserts the single flag.
            if (w_wrap)    pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    assign poll_pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/periph_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : periph_bus_master                                                |
// | Brief   : Command/response to peripheral-bus initiator with keypad poll.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module periph_bus_master
    import periph_pkg::*;
#(
    parameter int unsigned         ADDR_W      = 4,
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         RD_LAT      = 1,
    parameter int unsigned         POLL_PERIOD = C_POLL_PERIOD_DEF,
    parameter logic [ADDR_W-1:0]   KEY_ADDR    = ADDR_W'(C_KEY_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              poll_en,
    output logic              key_event,
    output logic [DATA_W-1:0] key_value,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] din,
    output logic              writeEnable,
    input  logic [DATA_W-1:0] dout
);

    localparam int unsigned C_LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e              state_q, state_d;
    logic [C_LAT_W-1:0]  lat_q, lat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   key_value_q, key_value_d;
    logic                key_event_q, key_event_d;

    logic w_poll_pending;
    logic w_lat_done;
    logic w_accept;
    logic w_poll_done;

    periph_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_poll_timer (
        .clk          (clk),
        .reset        (reset),
        .poll_en      (poll_en),
        .poll_done    (w_poll_done),
        .poll_pending (w_poll_pending)
    );

    // Gated by reset so the handshake is dead while reset is held.
    assign cmd_ready   = reset && (state_q == ST_IDLE) && !w_poll_pending;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_lat_done  = (lat_q == C_LAT_W'(RD_LAT - 1));
    assign w_poll_done = (state_q == ST_POLL) && w_lat_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            key_value_q <= '0;
            key_event_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            key_value_q <= key_value_d;
            key_event_q <= key_event_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_poll_pending)  state_d = ST_POLL;
                else if (cmd_valid)  state_d = cmd_write ? ST_WRITE : ST_READ;
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_READ:  if (w_lat_done) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready)  state_d = ST_IDLE;
            ST_POLL:  if (w_lat_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lat_d       = '0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        key_value_d = key_value_q;
        key_event_d = 1'b0;
        if ((state_q == ST_READ || state_q == ST_POLL) && !w_lat_done)
            lat_d = lat_q + 1'b1;
        if (w_accept) begin
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
        end
        if (state_q == ST_READ && w_lat_done)
            rdata_d = dout;
        if (w_poll_done && (dout != key_value_q)) begin
            key_value_d = dout;
            key_event_d = 1'b1;
        end
    end

    always_comb begin
        address     = '0;
        din         = '0;
        writeEnable = 1'b0;
        case (state_q)
            ST_WRITE: begin
                address     = addr_q;
                din         = wdata_q;
                writeEnable = 1'b1;
            end
            ST_READ:  address = addr_q;
            ST_POLL:  address = KEY_ADDR;
            default:  address = '0;
        endcase
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign key_event = key_event_q;
    assign key_value = key_value_q;

endmodule
`default_nettype wire

// File: tb/tb_periph_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_periph_bus_master                                             |
// | Brief   : Directed bench: RD_LAT=1 instance with fast polling, RD_LAT=3.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_periph_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready;
    logic        poll_en, key_event, writeEnable;
    logic [3:0]  cmd_addr, address;
    logic [31:0] cmd_wdata, rsp_rdata, key_value, din, dout;

    logic        cmd_valid3, cmd_ready3, cmd_write3, rsp_valid3, rsp_ready3;
    logic        poll_en3, key_event3, writeEnable3;
    logic [3:0]  cmd_addr3, address3;
    logic [31:0] cmd_wdata3, rsp_rdata3, key_value3, din3, dout3;

    logic [31:0] mem [16];
    logic [3:0]  a3_p1 = 4'h0, a3_p2 = 4'h0;
    int          cyc = 0;
    int          hs  = 0;

    // Single-cycle bus is combinational; the 3-cycle bus only shows the
    // data addressed two cycles earlier, so an early sample reads stale data.
    always_comb dout  = mem[address];
    always_comb dout3 = mem[a3_p2];

    always @(posedge clk) begin
        a3_p1 <= address3;
        a3_p2 <= a3_p1;
        cyc   <= cyc + 1;
        if (cmd_valid && cmd_ready) hs <= hs + 1;
    end

    periph_bus_master #(
        .ADDR_W(4), .DATA_W(32), .RD_LAT(1), .POLL_PERIOD(8), .KEY_ADDR(4'hF)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .poll_en(poll_en), .key_event(key_event), .key_value(key_value),
        .address(address), .din(din), .writeEnable(writeEnable), .dout(dout)
    );

    periph_bus_master #(
        .ADDR_W(4), .DATA_W(32), .RD_LAT(3), .POLL_PERIOD(8), .KEY_ADDR(4'hF)
    ) dut3 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write3),
        .cmd_addr(cmd_addr3), .cmd_wdata(cmd_wdata3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
        .poll_en(poll_en3), .key_event(key_event3), .key_value(key_value3),
        .address(address3), .din(din3), .writeEnable(writeEnable3), .dout(dout3)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Advances until the single-cycle instance drives the keypad address.
    task automatic wait_poll(input string tag, output int at);
        int found;
        found = 0;
        at    = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (address == 4'hF) begin
                found = 1;
                at    = cyc;
            end
        end
        chk(tag, found, 1);
    endtask

    int t_a, t_b, t_c, hs0, n_poll;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[5] = 32'hDEAD_BEEF;
        mem[6] = 32'hA5A5_0006;
        mem[7] = 32'h1234_5678;
        reset = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0; poll_en = 0;
        cmd_valid3 = 0; cmd_write3 = 0; cmd_addr3 = 0; cmd_wdata3 = 0; rsp_ready3 = 0; poll_en3 = 0;

        repeat (2) tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_address", address, 0);
        chk("rst_we", writeEnable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_key_value", key_value, 0);

        // Write addr 3 right after reset release
        reset = 1'b1;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd3; cmd_wdata = 32'h42;
        tick();
        chk("wr_we", writeEnable, 1);
        chk("wr_addr", address, 3);
        chk("wr_din", din, 32'h42);
        chk("wr_cmd_ready", cmd_ready, 0);
        cmd_valid = 0;
        tick();
        chk("wr_we_drop", writeEnable, 0);
        chk("wr_no_rsp", rsp_valid, 0);
        chk("wr_addr_idle", address, 0);

        // Read addr 5 with backpressure
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd5;
        chk("rd_cmd_ready", cmd_ready, 1);
        tick();
        chk("rd_addr", address, 5);
        chk("rd_we", writeEnable, 0);
        chk("rd_early_rsp", rsp_valid, 0);
        cmd_valid = 0;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_bus_idle", address, 0);
            if (i == 0) mem[5] = 32'h0;
            tick();
        end
        chk("bp_valid7", rsp_valid, 1);
        chk("bp_data7", rsp_rdata, 32'hDEAD_BEEF);
        rsp_ready = 1;
        tick();
        chk("bp_rsp_drop", rsp_valid, 0);
        chk("bp_cmd_ready_back", cmd_ready, 1);

        // Read with rsp_ready already high: one RESP cycle
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'd7;
        tick();
        cmd_valid = 0;
        tick();
        chk("rd1_valid", rsp_valid, 1);
        chk("rd1_data", rsp_rdata, 32'h1234_5678);
        tick();
        chk("rd1_one_cycle", rsp_valid, 0);
        rsp_ready = 0;

        // Back-to-back writes: one per two cycles
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd3; cmd_wdata = 32'h11;
        tick();
        chk("b2b_din_a", din, 32'h11);
        cmd_addr = 4'd4; cmd_wdata = 32'h22;
        tick();
        chk("b2b_gap_we", writeEnable, 0);
        chk("b2b_gap_ready", cmd_ready, 1);
        tick();
        chk("b2b_we_b", writeEnable, 1);
        chk("b2b_addr_b", address, 4);
        chk("b2b_din_b", din, 32'h22);
        cmd_valid = 0;
        tick();

        // Keypad polling: unchanged, changed, unchanged
        poll_en = 1;
        wait_poll("poll_a_seen", t_a);
        chk("poll_a_we", writeEnable, 0);
        chk("poll_a_cmd_ready", cmd_ready, 0);
        tick();
        chk("poll_a_no_event", key_event, 0);
        mem[15] = 32'h4;
        wait_poll("poll_b_seen", t_b);
        chk("poll_b_period", t_b - t_a, 8);
        tick();
        chk("poll_b_event", key_event, 1);
        chk("poll_b_value", key_value, 4);
        tick();
        chk("poll_b_pulse_end", key_event, 0);
        wait_poll("poll_c_seen", t_c);
        chk("poll_c_period", t_c - t_b, 8);
        tick();
        chk("poll_c_no_event", key_event, 0);
        chk("poll_c_value", key_value, 4);

        // Command offered while a poll is pending: poll first, then command once
        repeat (6) tick();
        chk("pend_cmd_ready", cmd_ready, 0);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'd2; cmd_wdata = 32'h55;
        hs0 = hs;
        tick();
        chk("pend_poll_first", address, 4'hF);
        tick();
        chk("pend_cmd_after", cmd_ready, 1);
        tick();
        chk("pend_wr_we", writeEnable, 1);
        chk("pend_wr_addr", address, 2);
        chk("pend_wr_din", din, 32'h55);
        cmd_valid = 0;
        tick();
        chk("pend_hs_once", hs - hs0, 1);

        // Disabling polling stops it
        poll_en = 0;
        n_poll = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (address == 4'hF) n_poll++;
        end
        chk("poll_off", n_poll, 0);

        // RD_LAT=3 read
        cmd_valid3 = 1; cmd_write3 = 0; cmd_addr3 = 4'd6;
        chk("l3_cmd_ready", cmd_ready3, 1);
        tick();
        cmd_valid3 = 0;
        chk("l3_addr_c1", address3, 6);
        tick();
        chk("l3_addr_c2", address3, 6);
        tick();
        chk("l3_addr_c3", address3, 6);
        chk("l3_no_rsp_c3", rsp_valid3, 0);
        tick();
        chk("l3_rsp_valid", rsp_valid3, 1);
        chk("l3_rsp_data", rsp_rdata3, 32'hA5A5_0006);
        rsp_ready3 = 1;
        tick();
        chk("l3_rsp_done", rsp_valid3, 0);
        rsp_ready3 = 0;

        // Reset during the RD_LAT=3 wait
        cmd_valid3 = 1; cmd_write3 = 0; cmd_addr3 = 4'd6;
        tick();
        cmd_valid3 = 0;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_addr", address3, 0);
        chk("mid_rst_cmd_ready", cmd_ready3, 0);
        chk("mid_rst_rsp", rsp_valid3, 0);
        chk("mid_rst_key_value", key_value, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rel_cmd_ready", cmd_ready3, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_rsp", rsp_valid3, 0);
        end
        cmd_valid3 = 1; cmd_write3 = 1; cmd_addr3 = 4'd1; cmd_wdata3 = 32'h77;
        tick();
        chk("post_rst_we", writeEnable3, 1);
        chk("post_rst_addr", address3, 1);
        chk("post_rst_din", din3, 32'h77);
        cmd_valid3 = 0;
        tick();
        chk("post_rst_we_drop", writeEnable3, 0);
        chk("l3_no_event", key_event3, 0);
        chk("l3_key_value", key_value3, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
